timebase_gen: RTL and testbench

- Parametrised timebase generator for the kitchen timer; next generation of the one-second/half-second/debounce counter.
- Divider lengths are parameters, and the block has a real IDLE/RUN/PAUSE run-control FSM.
- Pause-resume keeps the partial second, all pulses are registered, and there is a blink phase output and an elapsed-seconds counter.
- Sits between the debounced key logic and the minute/second down-counter and display blink logic.

---
 rtl/timebase_gen_if.sv | 45 ++++
 rtl/timebase_gen.sv | 152 +++++++++++++++
 tb/tb_timebase_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timebase_gen_if.sv
// Bundle of the run-control keys and timebase outputs for timebase_gen.
// The master side belongs to the key logic and display/counter consumers.
// The slave side belongs to the timebase generator itself.
interface timebase_gen_if #(
   parameter int SEC_W = 12
);

   logic             START;
   logic             STOP;
   logic             CLEAR;
   logic             SET_PUSH;
   logic             ONE_SEC_PULSE;
   logic             HALF_SEC_PULSE;
   logic             BLINK;
   logic             DEBOUNCE_PULSE;
   logic             RUNNING;
   logic [SEC_W-1:0] ELAPSED;

   modport master (
      output START,
      output STOP,
      output CLEAR,
      output SET_PUSH,
      input  ONE_SEC_PULSE,
      input  HALF_SEC_PULSE,
      input  BLINK,
      input  DEBOUNCE_PULSE,
      input  RUNNING,
      input  ELAPSED
   );

   modport slave (
      input  START,
      input  STOP,
      input  CLEAR,
      input  SET_PUSH,
      output ONE_SEC_PULSE,
      output HALF_SEC_PULSE,
      output BLINK,
      output DEBOUNCE_PULSE,
      output RUNNING,
      output ELAPSED
   );

endinterface

// File: rtl/timebase_gen.sv
// Kitchen timer timebase generator.
// Three prescalers run from CLK:
//   - A run-controlled second divider that drives ONE_SEC_PULSE and ELAPSED.
//   - A free-running half-second divider that drives HALF_SEC_PULSE and the BLINK phase.
//   - A free-running debounce strobe divider.
// An IDLE/RUN/PAUSE state machine gates the second divider. Pausing keeps the partial second.
// Every output is taken straight from a flop, so there is no combinational input-to-output path.
module timebase_gen #(
   parameter int SEC_DIV  = 244141,
   parameter int HALF_DIV = 122070,
   parameter int DEB_DIV  = 8192,
   parameter int SEC_W    = 12
) (
   input  logic           CLK,
   input  logic           RES_X,
   timebase_gen_if.slave  bus
);

   localparam int SEC_CW  = $clog2(SEC_DIV);
   localparam int HALF_CW = $clog2(HALF_DIV);
   localparam int DEB_CW  = $clog2(DEB_DIV);

   localparam logic [SEC_CW-1:0]  SEC_MAX  = SEC_CW'(SEC_DIV - 1);
   localparam logic [HALF_CW-1:0] HALF_MAX = HALF_CW'(HALF_DIV - 1);
   localparam logic [DEB_CW-1:0]  DEB_MAX  = DEB_CW'(DEB_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [SEC_CW-1:0]   sec_cnt;
   logic [SEC_CW-1:0]   sec_next;
   logic [SEC_W-1:0]    elapsed_q;
   logic [SEC_W-1:0]    elapsed_next;
   logic                sec_wrap;
   logic                one_sec_q;
   logic                running_q;

   logic [HALF_CW-1:0]  half_cnt;
   logic                half_pulse_q;
   logic                blink_q;

   logic [DEB_CW-1:0]   deb_cnt;
   logic                deb_pulse_q;

   // Run-control decisions. CLEAR beats STOP, and STOP beats START.
   // A second that wraps on the same edge that STOP is seen still completes.
   always_comb begin
      next_state   = state;
      sec_next     = sec_cnt;
      elapsed_next = elapsed_q;
      sec_wrap     = 1'b0;
      if (bus.CLEAR) begin
         next_state   = IDLE;
         sec_next     = '0;
         elapsed_next = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.START && !bus.STOP) begin
                  next_state = RUN;
                  sec_next   = '0;
               end
            end
            RUN: begin
               if (sec_cnt == SEC_MAX) begin
                  sec_next     = '0;
                  sec_wrap     = 1'b1;
                  elapsed_next = elapsed_q + SEC_W'(1);
               end else if (!bus.STOP) begin
                  sec_next = sec_cnt + SEC_CW'(1);
               end
               if (bus.STOP) begin
                  next_state = PAUSE;
               end
            end
            PAUSE: begin
               if (bus.START && !bus.STOP) begin
                  next_state = RUN;
               end
            end
            default: begin
               next_state = IDLE;
               sec_next   = '0;
            end
         endcase
      end
   end

   // Run-control state, second prescaler, elapsed count and their registered outputs.
   always_ff @(posedge CLK or negedge RES_X) begin
      if (!RES_X) begin
         state     <= IDLE;
         sec_cnt   <= '0;
         elapsed_q <= '0;
         one_sec_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= next_state;
         sec_cnt   <= sec_next;
         elapsed_q <= elapsed_next;
         one_sec_q <= sec_wrap;
         running_q <= (next_state == RUN);
      end
   end

   // Half-second divider and blink phase. A set key restarts the phase with the digits lit.
   always_ff @(posedge CLK or negedge RES_X) begin
      if (!RES_X) begin
         half_cnt     <= '0;
         half_pulse_q <= 1'b0;
         blink_q      <= 1'b1;
      end else if (bus.SET_PUSH) begin
         half_cnt     <= '0;
         half_pulse_q <= 1'b0;
         blink_q      <= 1'b1;
      end else if (half_cnt == HALF_MAX) begin
         half_cnt     <= '0;
         half_pulse_q <= 1'b1;
         blink_q      <= ~blink_q;
      end else begin
         half_cnt     <= half_cnt + HALF_CW'(1);
         half_pulse_q <= 1'b0;
      end
   end

   // Free-running debounce sample strobe. It ignores every control input.
   always_ff @(posedge CLK or negedge RES_X) begin
      if (!RES_X) begin
         deb_cnt     <= '0;
         deb_pulse_q <= 1'b0;
      end else if (deb_cnt == DEB_MAX) begin
         deb_cnt     <= '0;
         deb_pulse_q <= 1'b1;
      end else begin
         deb_cnt     <= deb_cnt + DEB_CW'(1);
         deb_pulse_q <= 1'b0;
      end
   end

   assign bus.ONE_SEC_PULSE  = one_sec_q;
   assign bus.HALF_SEC_PULSE = half_pulse_q;
   assign bus.BLINK          = blink_q;
   assign bus.DEBOUNCE_PULSE = deb_pulse_q;
   assign bus.RUNNING        = running_q;
   assign bus.ELAPSED        = elapsed_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen, built with small dividers.
// A reference model predicts every output per clock.
// Directed checks pin down the pulse positions named in the test plan.
module tb_timebase_gen;

   localparam int SEC_DIV  = 10;
   localparam int HALF_DIV = 5;
   localparam int DEB_DIV  = 4;
   localparam int SEC_W    = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   typedef struct {
      logic             one_sec;
      logic             half_sec;
      logic             blink;
      logic             debounce;
      logic             running;
      logic [SEC_W-1:0] elapsed;
   } exp_t;

   logic clk;
   logic res_x;

   timebase_gen_if #(.SEC_W(SEC_W)) tb_bus ();

   timebase_gen #(
      .SEC_DIV  (SEC_DIV),
      .HALF_DIV (HALF_DIV),
      .DEB_DIV  (DEB_DIV),
      .SEC_W    (SEC_W)
   ) dut (
      .CLK   (clk),
      .RES_X (res_x),
      .bus   (tb_bus)
   );

   exp_t sb_q[$];
   int   n_compared;
   int   n_mismatched;
   int   cyc;

   int   m_state;
   int   m_sec;
   int   m_elapsed;
   int   m_half;
   int   m_deb;
   bit   m_blink;

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_state   = M_IDLE;
      m_sec     = 0;
      m_elapsed = 0;
      m_half    = 0;
      m_deb     = 0;
      m_blink   = 1'b1;
      sb_q.delete();
   endtask

   // Predicts the outputs after the coming edge and queues them for the monitor.
   task automatic modelStep(input bit start, input bit stop, input bit clear, input bit set_push);
      exp_t e;
      e.one_sec  = 1'b0;
      e.half_sec = 1'b0;
      e.debounce = 1'b0;
      if (clear) begin
         m_state   = M_IDLE;
         m_sec     = 0;
         m_elapsed = 0;
      end else if (m_state == M_IDLE) begin
         if (start && !stop) begin
            m_state = M_RUN;
            m_sec   = 0;
         end
      end else if (m_state == M_RUN) begin
         if (m_sec == SEC_DIV - 1) begin
            m_sec     = 0;
            e.one_sec = 1'b1;
            m_elapsed = (m_elapsed + 1) % (1 << SEC_W);
         end else if (!stop) begin
            m_sec = m_sec + 1;
         end
         if (stop) m_state = M_PAUSE;
      end else begin
         if (start && !stop) m_state = M_RUN;
      end
      if (set_push) begin
         m_half  = 0;
         m_blink = 1'b1;
      end else if (m_half == HALF_DIV - 1) begin
         m_half     = 0;
         e.half_sec = 1'b1;
         m_blink    = ~m_blink;
      end else begin
         m_half = m_half + 1;
      end
      if (m_deb == DEB_DIV - 1) begin
         m_deb      = 0;
         e.debounce = 1'b1;
      end else begin
         m_deb = m_deb + 1;
      end
      e.blink   = m_blink;
      e.running = (m_state == M_RUN);
      e.elapsed = SEC_W'(m_elapsed);
      sb_q.push_back(e);
   endtask

   // Drives one cycle of inputs, lets the edge happen, then compares against the queued prediction.
   task automatic applyStimulus(input bit start, input bit stop, input bit clear, input bit set_push);
      exp_t e;
      tb_bus.START    = start;
      tb_bus.STOP     = stop;
      tb_bus.CLEAR    = clear;
      tb_bus.SET_PUSH = set_push;
      modelStep(start, stop, clear, set_push);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checkOutput("one_sec",  tb_bus.ONE_SEC_PULSE,  e.one_sec);
         checkOutput("half_sec", tb_bus.HALF_SEC_PULSE, e.half_sec);
         checkOutput("blink",    tb_bus.BLINK,          e.blink);
         checkOutput("debounce", tb_bus.DEBOUNCE_PULSE, e.debounce);
         checkOutput("running",  tb_bus.RUNNING,        e.running);
         checkOutput("elapsed",  tb_bus.ELAPSED,        e.elapsed);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_one_sec"},  tb_bus.ONE_SEC_PULSE,  0);
      checkOutput({tag, "_half_sec"}, tb_bus.HALF_SEC_PULSE, 0);
      checkOutput({tag, "_blink"},    tb_bus.BLINK,          1);
      checkOutput({tag, "_debounce"}, tb_bus.DEBOUNCE_PULSE, 0);
      checkOutput({tag, "_running"},  tb_bus.RUNNING,        0);
      checkOutput({tag, "_elapsed"},  tb_bus.ELAPSED,        0);
   endtask

   // Main sequence.
   initial begin
      int n_pulses;
      int guard;
      n_compared   = 0;
      n_mismatched = 0;
      cyc          = 0;
      res_x           = 1'b0;
      tb_bus.START    = 1'b0;
      tb_bus.STOP     = 1'b0;
      tb_bus.CLEAR    = 1'b0;
      tb_bus.SET_PUSH = 1'b0;
      modelReset();

      $display("[TB] reset state");
      @(posedge clk);
      #1;
      checkResetValues("reset");
      res_x = 1'b1;

      $display("[TB] idle after reset");
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(0, 0, 0, 0);
         if (i == 4)  checkOutput("deb_c4",   tb_bus.DEBOUNCE_PULSE, 1);
         if (i == 8)  checkOutput("deb_c8",   tb_bus.DEBOUNCE_PULSE, 1);
         if (i == 5)  checkOutput("half_c5",  tb_bus.HALF_SEC_PULSE, 1);
         if (i == 5)  checkOutput("blink_c5", tb_bus.BLINK, 0);
         if (i == 10) checkOutput("half_c10", tb_bus.HALF_SEC_PULSE, 1);
         if (i == 10) checkOutput("blink_c10", tb_bus.BLINK, 1);
      end

      $display("[TB] start and count three seconds");
      applyStimulus(1, 0, 0, 0);
      checkOutput("run_after_start", tb_bus.RUNNING, 1);
      for (int k = 1; k <= 30; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 9)  checkOutput("sec_c9",  tb_bus.ONE_SEC_PULSE, 0);
         if (k == 10) checkOutput("sec_c10", tb_bus.ONE_SEC_PULSE, 1);
         if (k == 20) checkOutput("sec_c20", tb_bus.ONE_SEC_PULSE, 1);
         if (k == 30) checkOutput("sec_c30", tb_bus.ONE_SEC_PULSE, 1);
      end
      checkOutput("elapsed_3", tb_bus.ELAPSED, 3);

      $display("[TB] pause and resume");
      applyStimulus(0, 0, 1, 0);
      checkOutput("clear_elapsed", tb_bus.ELAPSED, 0);
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("paused", tb_bus.RUNNING, 0);
      n_pulses = 0;
      for (int k = 5; k <= 26; k++) begin
         applyStimulus((k == 20), 0, 0, 0);
         n_pulses += int'(tb_bus.ONE_SEC_PULSE);
      end
      checkOutput("pause_no_pulse", n_pulses, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("resume_c27", tb_bus.ONE_SEC_PULSE, 1);

      $display("[TB] simultaneous inputs");
      applyStimulus(1, 1, 0, 0);
      checkOutput("start_stop_pause", tb_bus.RUNNING, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("rerun", tb_bus.RUNNING, 1);
      applyStimulus(1, 0, 1, 0);
      checkOutput("clear_start_run", tb_bus.RUNNING, 0);
      checkOutput("clear_start_elapsed", tb_bus.ELAPSED, 0);
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 9; k++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("stop_wrap_pulse", tb_bus.ONE_SEC_PULSE, 1);
      checkOutput("stop_wrap_elapsed", tb_bus.ELAPSED, 1);
      checkOutput("stop_wrap_running", tb_bus.RUNNING, 0);

      $display("[TB] blink restart");
      guard = 0;
      while (!(m_half == 3 && m_blink == 1'b0) && guard < 20) begin
         applyStimulus(0, 0, 0, 0);
         guard++;
      end
      checkOutput("blink_align", int'(m_half == 3 && m_blink == 1'b0), 1);
      checkOutput("blink_low_before_set", tb_bus.BLINK, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("set_blink", tb_bus.BLINK, 1);
      checkOutput("set_no_half", tb_bus.HALF_SEC_PULSE, 0);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(0, 0, 0, 0);
         checkOutput("half_after_set", tb_bus.HALF_SEC_PULSE, (k == 5) ? 1 : 0);
      end
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(0, 0, 0, 1);
         checkOutput("held_set_blink", tb_bus.BLINK, 1);
      end

      $display("[TB] elapsed wrap");
      applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 160; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 150) checkOutput("elapsed_15", tb_bus.ELAPSED, 15);
         if (k == 160) checkOutput("elapsed_wrap0", tb_bus.ELAPSED, 0);
      end

      $display("[TB] random control traffic");
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
      end

      $display("[TB] asynchronous reset mid-count");
      applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 13; k++) applyStimulus(0, 0, 0, 0);
      #3;
      res_x = 1'b0;
      #1;
      checkResetValues("async_reset");
      modelReset();
      @(posedge clk);
      #1;
      checkResetValues("held_reset");
      res_x = 1'b1;
      for (int k = 1; k <= 6; k++) applyStimulus(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
